// File: rtl/csa_sub_64.sv
// Two-stage pipelined 64-bit carry-select subtractor (a - b - bin) with
// valid/ready handshake and borrow/zero/negative/overflow flags.
module csa_sub_64 (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  logic        bin,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] diff,
  output logic        bout,
  output logic        zero,
  output logic        neg,
  output logic        ovf
);

  localparam int unsigned W  = 64;
  localparam int unsigned HW = 32;

  logic          v1_q, v1_d, v2_q, v2_d;
  logic [HW-1:0] d_lo_q, d_lo_d, h0_q, h0_d, h1_q, h1_d;
  logic          br_lo_q, br_lo_d, bo0_q, bo0_d, bo1_q, bo1_d;
  logic          a_msb_q, a_msb_d, b_msb_q, b_msb_d;
  logic [W-1:0]  diff_q, diff_d;
  logic          bout_q, bout_d, zero_q, zero_d, neg_q, neg_d, ovf_q, ovf_d;

  logic          adv1, adv2;
  logic [HW:0]   sum_lo, sum_h0, sum_h1;
  logic [HW-1:0] sel_hi;
  logic          sel_bo;

  assign adv2     = v1_q && (!v2_q || out_ready);
  assign in_ready = !v1_q || adv2;
  assign adv1     = in_valid && in_ready;

  // Subtraction as a + ~b + ~borrow_in; an inverted carry-out is the borrow.
  always_comb begin
    sum_lo = {1'b0, a[HW-1:0]} + {1'b0, ~b[HW-1:0]} + (HW+1)'(!bin);
    sum_h0 = {1'b0, a[W-1:HW]} + {1'b0, ~b[W-1:HW]} + (HW+1)'(1'b1);
    sum_h1 = {1'b0, a[W-1:HW]} + {1'b0, ~b[W-1:HW]};
  end

  always_comb begin
    v1_d    = v1_q;
    v2_d    = v2_q;
    d_lo_d  = d_lo_q;
    br_lo_d = br_lo_q;
    h0_d    = h0_q;
    bo0_d   = bo0_q;
    h1_d    = h1_q;
    bo1_d   = bo1_q;
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
    zero_d  = zero_q;
    neg_d   = neg_q;
    ovf_d   = ovf_q;
    sel_hi  = br_lo_q ? h1_q : h0_q;
    sel_bo  = br_lo_q ? bo1_q : bo0_q;

    if (adv1) begin
      v1_d    = 1'b1;
      d_lo_d  = sum_lo[HW-1:0];
      br_lo_d = !sum_lo[HW];
      h0_d    = sum_h0[HW-1:0];
      bo0_d   = !sum_h0[HW];
      h1_d    = sum_h1[HW-1:0];
      bo1_d   = !sum_h1[HW];
      a_msb_d = a[W-1];
      b_msb_d = b[W-1];
    end else if (adv2) begin
      v1_d = 1'b0;
    end

    if (adv2) begin
      v2_d   = 1'b1;
      diff_d = {sel_hi, d_lo_q};
      bout_d = sel_bo;
      zero_d = ({sel_hi, d_lo_q} == '0);
      neg_d  = sel_hi[HW-1];
      ovf_d  = (a_msb_q != b_msb_q) && (sel_hi[HW-1] != a_msb_q);
    end else if (out_ready) begin
      v2_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      d_lo_q  <= '0;
      br_lo_q <= 1'b0;
      h0_q    <= '0;
      bo0_q   <= 1'b0;
      h1_q    <= '0;
      bo1_q   <= 1'b0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      v1_q    <= v1_d;
      v2_q    <= v2_d;
      d_lo_q  <= d_lo_d;
      br_lo_q <= br_lo_d;
      h0_q    <= h0_d;
      bo0_q   <= bo0_d;
      h1_q    <= h1_d;
      bo1_q   <= bo1_d;
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
      zero_q  <= zero_d;
      neg_q   <= neg_d;
      ovf_q   <= ovf_d;
    end
  end

  assign out_valid = v2_q;
  assign diff      = diff_q;
  assign bout      = bout_q;
  assign zero      = zero_q;
  assign neg       = neg_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_csa_sub_64.sv
// Self-checking bench for csa_sub_64: directed vectors, backpressure, reset
// and randomized streaming against an arithmetic reference model.
module tb_csa_sub_64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] a = '0;
  logic [63:0] b = '0;
  logic        bin = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] diff;
  logic        bout, zero, neg, ovf;

  csa_sub_64 dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .bin(bin), .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff), .bout(bout), .zero(zero), .neg(neg), .ovf(ovf)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned n_acc    = 0;
  int unsigned n_out    = 0;

  logic [67:0] sb[$];
  logic        last_acc, ov_s, ir_s;
  logic [63:0] diff_s;
  logic [3:0]  flg_s;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: {diff, bout, zero, neg, ovf} from plain wide arithmetic.
  function automatic logic [67:0] model(input logic [63:0] ma, input logic [63:0] mb,
                                        input logic mbin);
    logic [64:0]        full;
    logic signed [65:0] s;
    logic [63:0]        d;
    logic               br, of;
    full = {1'b0, ma} - {1'b0, mb} - 65'(mbin);
    d    = full[63:0];
    br   = ({1'b0, ma} < ({1'b0, mb} + 65'(mbin)));
    s    = $signed({{2{ma[63]}}, ma}) - $signed({{2{mb[63]}}, mb}) - $signed({65'd0, mbin});
    of   = (s > $signed(66'h0_7FFF_FFFF_FFFF_FFFF)) || (s < -$signed(66'h0_8000_0000_0000_0000));
    return {d, br, (d == 64'd0), d[63], of};
  endfunction

  // One cycle: drive at negedge, sample 1 time unit later, score, then pass the edge.
  task automatic step(input logic iv, input logic [63:0] ta, input logic [63:0] tb_v,
                      input logic tbin, input logic ordy);
    logic [67:0] e;
    @(negedge clk);
    in_valid = iv; a = ta; b = tb_v; bin = tbin; out_ready = ordy;
    #1;
    ov_s = out_valid; ir_s = in_ready; diff_s = diff; flg_s = {bout, zero, neg, ovf};
    last_acc = in_valid && in_ready;
    if (out_valid) begin
      if (sb.size() == 0) begin
        check("spurious_out", 64'(out_valid), 64'd0);
      end else begin
        e = sb[0];
        check("sb_diff", diff, e[67:4]);
        check("sb_flags", 64'(flg_s), 64'(e[3:0]));
      end
    end
    if (out_valid && out_ready && sb.size() > 0) begin
      sb.pop_front();
      n_out++;
    end
    if (last_acc) begin
      sb.push_back(model(ta, tb_v, tbin));
      n_acc++;
    end
    @(posedge clk);
  endtask

  // Single operation through an empty pipe, checked against fixed values.
  task automatic run_one(input string tag, input logic [63:0] ta, input logic [63:0] tb_v,
                         input logic tbin, input logic [63:0] ed, input logic [3:0] ef);
    step(1'b1, ta, tb_v, tbin, 1'b1);
    check({tag, "_accept"}, 64'(last_acc), 64'd1);
    step(1'b0, '0, '0, 1'b0, 1'b1);
    check({tag, "_early"}, 64'(ov_s), 64'd0);
    step(1'b0, '0, '0, 1'b0, 1'b1);
    check({tag, "_valid"}, 64'(ov_s), 64'd1);
    check({tag, "_diff"}, diff_s, ed);
    check({tag, "_flags"}, 64'(flg_s), 64'(ef));
  endtask

  initial begin
    int unsigned acc_bp, cyc;
    logic [63:0] ra, rb;

    repeat (2) @(posedge clk);
    #2;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_diff", diff, 64'd0);
    check("rst_flags", 64'({bout, zero, neg, ovf}), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    run_one("basic", 64'h0000_0001_0000_0000, 64'd1, 1'b0, 64'h0000_0000_FFFF_FFFF, 4'b0000);
    run_one("borrow", 64'd0, 64'd0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 4'b1010);
    run_one("equal", 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 1'b0, 64'd0, 4'b0100);
    run_one("ovf_neg", 64'h8000_0000_0000_0000, 64'd1, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 4'b0001);
    run_one("ovf_pos", 64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0,
            64'h8000_0000_0000_0000, 4'b1011);

    // Backpressure: only two transfers fit while the consumer stalls.
    acc_bp = 0;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom), 1'b0);
      if (last_acc) acc_bp++;
    end
    check("bp_accepts", 64'(acc_bp), 64'd2);
    check("bp_in_ready", 64'(ir_s), 64'd0);
    step(1'b1, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom), 1'b1);
    check("bp_passthru", 64'(ir_s), 64'd1);
    for (int i = 0; i < 4; i++) step(1'b0, '0, '0, 1'b0, 1'b1);
    check("bp_drained", 64'(sb.size()), 64'd0);

    // Reset with two operations in flight.
    step(1'b1, 64'd100, 64'd1, 1'b0, 1'b0);
    step(1'b1, 64'd200, 64'd2, 1'b0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("mrst_out_valid", 64'(out_valid), 64'd0);
    check("mrst_in_ready", 64'(in_ready), 64'd1);
    check("mrst_diff", diff, 64'd0);
    check("mrst_flags", 64'({bout, zero, neg, ovf}), 64'd0);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    step(1'b0, '0, '0, 1'b0, 1'b1);
    check("mrst_no_stale", 64'(ov_s), 64'd0);
    run_one("post_rst", 64'd10, 64'd3, 1'b1, 64'd6, 4'b0000);

    // Randomized streaming with random valid/ready.
    n_acc = 0;
    n_out = 0;
    cyc = 0;
    while (n_acc < 1000 && cyc < 20000) begin
      ra = {$urandom, $urandom};
      case ($urandom_range(0, 7))
        0: rb = ra;
        1: rb = ra + 64'd1;
        2: rb = {ra[63:32], $urandom};
        default: rb = {$urandom, $urandom};
      endcase
      step(($urandom_range(0, 3) != 0), ra, rb, 1'($urandom), ($urandom_range(0, 3) != 0));
      cyc++;
    end
    check("stream_budget", 64'(n_acc), 64'd1000);
    cyc = 0;
    while (sb.size() > 0 && cyc < 10) begin
      step(1'b0, '0, '0, 1'b0, 1'b1);
      cyc++;
    end
    check("stream_drain", 64'(sb.size()), 64'd0);
    check("stream_count", 64'(n_out), 64'(n_acc));
    step(1'b0, '0, '0, 1'b0, 1'b1);
    check("stream_idle", 64'(ov_s), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
